// File: rtl/display_pkg.sv
// Shared types and helpers for the display-mode controller.
package display_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic [1:0] {RELEASED, HELD, LONG} press_state_t;
    typedef enum logic {IDLE, BUSY} conv_state_t;

    function automatic int mode_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/press_classifier.sv
// Classifies button presses as short (released before the long-press
// threshold) or long (held through LONG_PRESS_S second strobes).
module press_classifier
    import display_pkg::*;
#(
    parameter int LONG_PRESS_S = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic mode,
    input  logic sec_pulse,
    output logic short_press,
    output logic long_press
);

    localparam int CNT_W = $clog2(LONG_PRESS_S + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_PRESS_S - 1);

    press_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state logic; a release in HELD wins over a coincident second strobe.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        short_press = 1'b0;
        long_press  = 1'b0;
        case (state_q)
            RELEASED: begin
                if (mode) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    state_d = RELEASED;
                end
            end
            HELD: begin
                if (!mode) begin
                    short_press = 1'b1;
                    state_d     = RELEASED;
                end else if (sec_pulse) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        long_press = 1'b1;
                        state_d    = LONG;
                    end else begin
                        state_d = HELD;
                    end
                end else begin
                    state_d = HELD;
                end
            end
            LONG: begin
                if (!mode) begin
                    state_d = RELEASED;
                end else begin
                    state_d = LONG;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/display_mode_ctrl.sv
// Display-mode controller: mode sequencing, indicator blinking and a
// coalescing request/valid handshake with the binary-to-ASCII converter.
module display_mode_ctrl
    import display_pkg::*;
#(
    parameter int                    NUM_MODES    = 4,
    parameter int                    SPEED_W      = 7,
    parameter int                    SPEED_LIMIT  = 65,
    parameter int                    DIGITS       = 6,
    parameter logic [NUM_MODES-1:0]  POINT_MASK   = 4'b0011,
    parameter int                    COL_MODE     = 2,
    parameter int                    LONG_PRESS_S = 2,
    parameter int                    TIMEOUT_CYC  = 1023,
    localparam int                   MODE_W       = mode_w(NUM_MODES)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mode,
    input  logic                       half_sec_pulse,
    input  logic                       sec_pulse,
    input  logic [SPEED_W-1:0]         speed,
    output logic                       conv_start,
    output logic [MODE_W-1:0]          conv_mode,
    input  logic                       conv_valid,
    input  logic [CHAR_W*DIGITS-1:0]   conv_digits,
    output logic [CHAR_W*DIGITS-1:0]   disp,
    output logic                       point,
    output logic                       col,
    output logic [NUM_MODES-1:0]       ind,
    output logic                       clear_req,
    output logic [MODE_W-1:0]          clear_mode,
    output logic                       conv_err
);

    localparam int                   TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int                   FRAME_W   = CHAR_W * DIGITS;
    localparam logic [MODE_W-1:0]    LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0]    COL_IDX   = MODE_W'(COL_MODE);
    localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [NUM_MODES-1:0] ONE_HOT0  = NUM_MODES'(1);

    logic short_press_s, long_press_s, req_s, overspeed_s;

    logic [MODE_W-1:0]    mode_idx_q, mode_idx_d;
    logic                 blink_q, blink_d;
    logic                 init_q, init_d;
    logic                 adv_q, adv_d;
    conv_state_t          conv_state_q, conv_state_d;
    logic                 pend_q, pend_d;
    logic                 pend_sec_q, pend_sec_d;
    logic                 conv_sec_q, conv_sec_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 conv_start_q, conv_start_d;
    logic [MODE_W-1:0]    conv_mode_q, conv_mode_d;
    logic [FRAME_W-1:0]   disp_q, disp_d;
    logic                 point_q, point_d;
    logic                 col_q, col_d;
    logic [NUM_MODES-1:0] ind_q, ind_d;
    logic                 clear_req_q, clear_req_d;
    logic [MODE_W-1:0]    clear_mode_q, clear_mode_d;
    logic                 conv_err_q, conv_err_d;

    press_classifier #(
        .LONG_PRESS_S (LONG_PRESS_S)
    ) u_press (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .sec_pulse   (sec_pulse),
        .short_press (short_press_s),
        .long_press  (long_press_s)
    );

    assign overspeed_s = (speed > SPEED_W'(SPEED_LIMIT));
    // The advance request is delayed one cycle so the conversion sees the new mode.
    assign req_s = init_q | sec_pulse | adv_q;

    // Mode index, blink phase, indicators and the clear strobe.
    always_comb begin
        if (short_press_s) begin
            mode_idx_d = (mode_idx_q == LAST_MODE) ? '0 : mode_idx_q + MODE_W'(1);
        end else begin
            mode_idx_d = mode_idx_q;
        end
        blink_d = half_sec_pulse ? ~blink_q : blink_q;
        adv_d   = short_press_s;
        init_d  = 1'b0;
        if (overspeed_s && blink_q) begin
            ind_d = '1;
        end else begin
            ind_d = ONE_HOT0 << mode_idx_q;
        end
        clear_req_d = long_press_s;
        if (long_press_s) begin
            clear_mode_d = mode_idx_q;
        end else begin
            clear_mode_d = clear_mode_q;
        end
    end

    // Converter handshake: start, coalescing, timeout and atomic frame latch.
    always_comb begin
        conv_state_d = conv_state_q;
        pend_d       = pend_q;
        pend_sec_d   = pend_sec_q;
        conv_sec_d   = conv_sec_q;
        tmo_d        = tmo_q;
        conv_start_d = 1'b0;
        conv_mode_d  = conv_mode_q;
        disp_d       = disp_q;
        point_d      = point_q;
        col_d        = col_q;
        conv_err_d   = conv_err_q;
        case (conv_state_q)
            IDLE: begin
                if (req_s || pend_q) begin
                    conv_start_d = 1'b1;
                    conv_mode_d  = mode_idx_q;
                    conv_sec_d   = sec_pulse | pend_sec_q;
                    pend_d       = 1'b0;
                    pend_sec_d   = 1'b0;
                    tmo_d        = '0;
                    conv_state_d = BUSY;
                end else begin
                    conv_state_d = IDLE;
                end
            end
            BUSY: begin
                if (req_s) begin
                    pend_d     = 1'b1;
                    pend_sec_d = pend_sec_q | sec_pulse;
                end else begin
                    pend_d     = pend_q;
                end
                if (conv_valid) begin
                    disp_d       = conv_digits;
                    point_d      = POINT_MASK[conv_mode_q];
                    col_d        = (conv_mode_q == COL_IDX) ? (col_q ^ conv_sec_q) : 1'b0;
                    conv_err_d   = 1'b0;
                    conv_state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    conv_err_d   = 1'b1;
                    conv_state_d = IDLE;
                end else begin
                    tmo_d        = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                conv_state_d = IDLE;
            end
        endcase
    end

    // All state and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_idx_q   <= '0;
            blink_q      <= 1'b0;
            init_q       <= 1'b1;
            adv_q        <= 1'b0;
            conv_state_q <= IDLE;
            pend_q       <= 1'b0;
            pend_sec_q   <= 1'b0;
            conv_sec_q   <= 1'b0;
            tmo_q        <= '0;
            conv_start_q <= 1'b0;
            conv_mode_q  <= '0;
            disp_q       <= '0;
            point_q      <= 1'b0;
            col_q        <= 1'b0;
            ind_q        <= '0;
            clear_req_q  <= 1'b0;
            clear_mode_q <= '0;
            conv_err_q   <= 1'b0;
        end else begin
            mode_idx_q   <= mode_idx_d;
            blink_q      <= blink_d;
            init_q       <= init_d;
            adv_q        <= adv_d;
            conv_state_q <= conv_state_d;
            pend_q       <= pend_d;
            pend_sec_q   <= pend_sec_d;
            conv_sec_q   <= conv_sec_d;
            tmo_q        <= tmo_d;
            conv_start_q <= conv_start_d;
            conv_mode_q  <= conv_mode_d;
            disp_q       <= disp_d;
            point_q      <= point_d;
            col_q        <= col_d;
            ind_q        <= ind_d;
            clear_req_q  <= clear_req_d;
            clear_mode_q <= clear_mode_d;
            conv_err_q   <= conv_err_d;
        end
    end

    assign conv_start = conv_start_q;
    assign conv_mode  = conv_mode_q;
    assign disp       = disp_q;
    assign point      = point_q;
    assign col        = col_q;
    assign ind        = ind_q;
    assign clear_req  = clear_req_q;
    assign clear_mode = clear_mode_q;
    assign conv_err   = conv_err_q;

endmodule
